collision_checker: RTL

Per-frame collision detector that sits directly upstream of the player-lives counter. On each frame tick it scans a table of obstacle bounding boxes and tests each one against the player's box. On a hit it issues one life-decrement request over an enable/ready handshake, then opens an invulnerability window of a set number of frames.

---
 rtl/collision_checker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/collision_checker.sv
// Per-frame obstacle scan against the player box; on a hit, issues one
// life-decrement handshake and then opens an invulnerability window.
module collision_checker #(
  parameter int NUM_OBSTACLES = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_H      = 16,
  parameter int OBST_W        = 16,
  parameter int OBST_H        = 16,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frameTick,
  input  logic [9:0]            playerX,
  input  logic [9:0]            playerY,
  output logic [ADDR_WIDTH-1:0] obstacleAddr,
  input  logic [9:0]            obstacleX,
  input  logic [9:0]            obstacleY,
  input  logic                  obstacleValid,
  input  logic                  livesReady,
  input  logic                  livesGameOver,
  output logic                  livesEnable,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] hitIndex,
  output logic                  invulnerable
);

  typedef enum logic [2:0] {IDLE, SCAN, RESULT, REQUEST, ACK} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_OBSTACLES - 1);
  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH + 1)'(NUM_OBSTACLES);
  localparam logic [7:0]            INV_LOAD  = 8'(INVULN_FRAMES);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [9:0]            px_q, py_q;
  logic                  accHit_q;
  logic [ADDR_WIDTH-1:0] accIdx_q;
  logic                  hit_q;
  logic [ADDR_WIDTH-1:0] hitIdx_q;
  logic                  done_q;
  logic                  en_q;
  logic [7:0]            invCnt_q;
  logic                  blocked_q;

  logic [ADDR_WIDTH-1:0] cmpIdx_d;
  logic                  overlap_d;

  // Read data lags the address by one cycle, so cnt_q-1 names the entry on the bus.
  always_comb begin
    cmpIdx_d  = ADDR_WIDTH'(cnt_q - 1'b1);
    overlap_d = obstacleValid
             && ({1'b0, px_q} < ({1'b0, obstacleX} + 11'(OBST_W)))
             && ({1'b0, obstacleX} < ({1'b0, px_q} + 11'(PLAYER_W)))
             && ({1'b0, py_q} < ({1'b0, obstacleY} + 11'(OBST_H)))
             && ({1'b0, obstacleY} < ({1'b0, py_q} + 11'(PLAYER_H)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      accHit_q  <= 1'b0;
      accIdx_q  <= '0;
      hit_q     <= 1'b0;
      hitIdx_q  <= '0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      invCnt_q  <= '0;
      blocked_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frameTick) begin
            px_q      <= playerX;
            py_q      <= playerY;
            addr_q    <= '0;
            cnt_q     <= '0;
            accHit_q  <= 1'b0;
            accIdx_q  <= '0;
            // Frame is blocked if the window was open at the tick, so a full
            // INVULN_FRAMES frames pass before the next request.
            blocked_q <= (invCnt_q != '0);
            if (invCnt_q != '0) invCnt_q <= invCnt_q - 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          cnt_q <= cnt_q + 1'b1;
          if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
          if ((cnt_q != '0) && overlap_d && !accHit_q) begin
            accHit_q <= 1'b1;
            accIdx_q <= cmpIdx_d;
          end
          if (cnt_q == LAST_CNT) begin
            hit_q    <= accHit_q | overlap_d;
            hitIdx_q <= accHit_q ? accIdx_q : (overlap_d ? cmpIdx_d : '0);
            done_q   <= 1'b1;
            state_q  <= RESULT;
          end
        end
        RESULT: begin
          state_q <= (hit_q && !blocked_q && !livesGameOver) ? REQUEST : IDLE;
        end
        REQUEST: begin
          if (livesGameOver) begin
            state_q <= IDLE;
          end else if (livesReady) begin
            en_q    <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (livesGameOver) begin
            en_q    <= 1'b0;
            state_q <= IDLE;
          end else if (!livesReady) begin
            en_q     <= 1'b0;
            invCnt_q <= INV_LOAD;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign obstacleAddr = addr_q;
  assign livesEnable  = en_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign hit          = hit_q;
  assign hitIndex     = hitIdx_q;
  assign invulnerable = (invCnt_q != '0);

endmodule
